// File: rtl/display_word_hex.sv
// -----------------------------------------------------------------------------
// display_word_hex
//
// Sequencer sitting directly upstream of display_hex. It latches a word of
// NIBBLES hex digits and hands it to display_hex one nibble at a time, most
// significant first. Each nibble gets one start/done handshake. A single
// word_done pulse marks the end of the whole word.
//
// Optional feature (compile-time macro): DISPLAY_WORD_ZSUPP_EN
//   When defined, leading zero nibbles are suppressed. The first digit shown
//   is the most significant non-zero nibble. An all-zero word shows one '0'.
//   When undefined, all NIBBLES digits are always shown.
//
// Parameters
//   NIBBLES              number of hex digits (1..8); word width is 4*NIBBLES
//
// Ports
//   clock                system clock, all state on the rising edge
//   reset_n              asynchronous active-low reset
//   word_in              word to display, sampled only when a start is accepted
//   word_start           request, accepted only while idle
//   lcd_initDone         LCD controller ready; gates every digit issue
//   display_hex_done     one-cycle pulse from display_hex: character written
//   display_hex_data_in  nibble presented to display_hex
//   display_hex_start    one-cycle request to display_hex
//   word_busy            high whenever a word is in progress
//   word_done            one-cycle pulse when the last digit has completed
// -----------------------------------------------------------------------------
module display_word_hex #(
  parameter int NIBBLES = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [4*NIBBLES-1:0]   word_in,
  input  logic                   word_start,
  input  logic                   lcd_initDone,
  input  logic                   display_hex_done,
  output logic [3:0]             display_hex_data_in,
  output logic                   display_hex_start,
  output logic                   word_busy,
  output logic                   word_done
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                 state;
  logic [4*NIBBLES-1:0]   word_q;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       start_idx;

  // Nibble view of the latched word so the current digit is a plain index.
  logic [3:0] nib [NIBBLES];

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign nib[gi] = word_q[4*gi +: 4];
  end

`ifdef DISPLAY_WORD_ZSUPP_EN
  // Priority encoder: index of the most significant non-zero nibble of the
  // incoming word. An all-zero word yields 0 so a single '0' is shown.
  logic [NIBBLES-1:0] nz;

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nz
    assign nz[gi] = |word_in[4*gi +: 4];
  end

  always_comb begin
    start_idx = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (nz[i]) start_idx = IDX_W'(i);
    end
  end
`else
  assign start_idx = IDX_W'(NIBBLES - 1);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      word_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (word_start) begin
            word_q <= word_in;
            idx    <= start_idx;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (lcd_initDone) state <= WAIT;
        end
        WAIT: begin
          if (display_hex_done) begin
            if (idx == '0) begin
              state <= FINISH;
            end else begin
              idx   <= idx - IDX_W'(1);
              state <= ISSUE;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // display_hex decodes its data combinationally for the whole write, so the
  // nibble is held from ISSUE through WAIT and forced to 0 otherwise.
  assign display_hex_data_in = (state == ISSUE || state == WAIT) ? nib[idx] : 4'h0;

  // The request is the ISSUE state qualified by LCD readiness: while the LCD
  // is not initialised the sequencer sits in ISSUE with start held low.
  assign display_hex_start = (state == ISSUE) && lcd_initDone;
  assign word_busy         = (state != IDLE);
  assign word_done         = (state == FINISH);

endmodule
